rank_insert_ctrl: RTL and testbench
===================================

RANK_INSERT_CTRL -- requirements
Module: rank_insert_ctrl

Interface
REQ-001 SHALL have parameter FLOW_ID_WIDTH, default 16, flow identifier width.
REQ-002 SHALL have parameter FLOW_WEIGHT_WIDTH, default 8, flow weight width.
REQ-003 SHALL have parameter MAX_NUM_FLOWS, default 4, number of flow-table entries; IDX_W = clog2(MAX_NUM_FLOWS).
REQ-004 SHALL have parameter RANK_CODE_BITS, default 2, rank-op code width.
REQ-005 SHALL have parameter META_WIDTH, default 16, metadata width.
REQ-006 SHALL have parameter NUM_RANK_OPS, default 1, number of implemented rank ops.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port cfg_wr_en, input, 1, write one flow-table entry.
REQ-010 SHALL have port cfg_idx, input, IDX_W, entry index.
REQ-011 SHALL have ports cfg_flowID / cfg_rank_op / cfg_weight, input, FLOW_ID_WIDTH / RANK_CODE_BITS / FLOW_WEIGHT_WIDTH, entry contents.
REQ-012 SHALL have port cfg_clr, input, 1, invalidate all entries.
REQ-013 SHALL have ports desc_valid (input, 1), desc_ready (output, 1), desc_flowID (input, FLOW_ID_WIDTH), desc_meta (input, META_WIDTH), the descriptor stream.
REQ-014 SHALL have port busy, input, 1, rank-pipe backpressure; insert is legal only when busy==0.
REQ-015 SHALL have ports insert (output, 1), meta_in, rank_op_in, flowID_in, flow_weight_in (outputs; META_WIDTH, RANK_CODE_BITS, FLOW_ID_WIDTH, FLOW_WEIGHT_WIDTH), driving the rank-pipe insert interface.
REQ-016 SHALL have port miss_count, output, 32, count of table misses.

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP, ISSUE.
REQ-018 SHALL drive desc_ready=1 only in IDLE, and SHALL capture flowID/meta and go to LOOKUP on desc_valid && desc_ready.
REQ-019 SHALL, in LOOKUP, compare the captured flowID against all valid entries in one cycle, register rank_op/weight/hit, and go to ISSUE.
REQ-020 SHALL select the lowest-index matching entry when several match.
REQ-021 SHALL, on miss, use rank_op=0 and weight=1 and increment miss_count, saturating at 0xFFFFFFFF.
REQ-022 SHALL replace any table rank_op >= NUM_RANK_OPS with 0 before issue.
REQ-023 SHALL, in ISSUE, assert insert for exactly one cycle, the first cycle with busy==0, with all insert-side data stable while in ISSUE, then return to IDLE.
REQ-024 SHALL drive insert=0 and all insert-side data to 0 outside the issue cycle.
REQ-025 SHALL yield minimum latency of 2 cycles from descriptor accept to insert, and throughput of one descriptor per 3 cycles when busy==0.
REQ-026 SHALL let a cfg write or cfg_clr in the LOOKUP cycle take effect after that lookup (lookup sees old contents); cfg_clr has priority over cfg_wr_en in the same cycle.
REQ-027 SHALL never lose a captured descriptor while busy stays high (unbounded wait in ISSUE).

Reset
REQ-028 SHALL, on rst (including mid-operation), enter IDLE, clear all valid bits, clear miss_count, and drive insert=0, desc_ready=0 during the reset cycle; any in-flight descriptor is discarded.

Configuration
REQ-029 SHALL, when RANK_INSERT_CTRL_MISS_DROP_EN is defined, drop missed descriptors (no insert, LOOKUP returns to IDLE, miss_count increments); without it, misses are inserted with the REQ-021 defaults.

Structure
REQ-030 SHALL place FSM state encoding and default miss rank_op/weight constants in shared package rank_pkg.
REQ-031 SHALL implement the table and match logic in sub-module rank_flow_table.

Verification
REQ-032 Entry 0 = {flowID 0x0005, op 0, weight 3}; descriptor flowID 0x0005, meta 0xABCD, busy=0 -> insert 2 cycles after accept with meta_in 0xABCD, flow_weight_in 3.
REQ-033 Descriptor flowID 0x0009 with no matching entry -> insert with op 0, weight 1; miss_count 1 (with MISS_DROP_EN: no insert, miss_count 1).
REQ-034 busy held high 10 cycles during ISSUE -> insert absent, data stable, desc_ready 0; single insert on first busy==0 cycle.
REQ-035 Entries 1 and 3 both flowID 0x0007 with weights 4 and 8 -> issued weight 4; entry op 3 with NUM_RANK_OPS=1 -> rank_op_in 0.
REQ-036 rst asserted in ISSUE -> next cycle insert 0, IDLE, miss_count 0; prior flowID now misses.

Source files
------------

// File: rtl/rank_insert_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rank_pkg
// Description : Shared definitions for the rank insert controller: FSM state
//               encoding and the rank_op/weight used for flow-table misses.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rank_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_lookup = 2'd1;
    localparam state_t c_st_issue  = 2'd2;

    // Values issued for a descriptor whose flowID is not in the table.
    localparam int unsigned c_miss_rank_op = 0;
    localparam int unsigned c_miss_weight  = 1;

endpackage
`default_nettype wire

// File: rtl/rank_insert_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rank_insert_if
// Description : Descriptor stream plus rank-pipe insert bundle.
// Ports       : master - descriptor source / rank pipe side
//               slave  - rank_insert_ctrl side (accepts descriptors,
//                        drives insert + insert data, observes busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface rank_insert_if #(
    parameter int FLOW_ID_WIDTH     = 16,
    parameter int FLOW_WEIGHT_WIDTH = 8,
    parameter int RANK_CODE_BITS    = 2,
    parameter int META_WIDTH        = 16
);
    logic                         desc_valid;
    logic                         desc_ready;
    logic [FLOW_ID_WIDTH-1:0]     desc_flowID;
    logic [META_WIDTH-1:0]        desc_meta;
    logic                         busy;
    logic                         insert;
    logic [META_WIDTH-1:0]        meta_in;
    logic [RANK_CODE_BITS-1:0]    rank_op_in;
    logic [FLOW_ID_WIDTH-1:0]     flowID_in;
    logic [FLOW_WEIGHT_WIDTH-1:0] flow_weight_in;

    modport master (
        output desc_valid, desc_flowID, desc_meta, busy,
        input  desc_ready, insert, meta_in, rank_op_in, flowID_in, flow_weight_in
    );

    modport slave (
        input  desc_valid, desc_flowID, desc_meta, busy,
        output desc_ready, insert, meta_in, rank_op_in, flowID_in, flow_weight_in
    );

endinterface
`default_nettype wire

// File: rtl/rank_insert_ctrl_flow_table.sv
`default_nettype none
// ============================================================================
// Module      : rank_flow_table
// Description : Flow table (flowID -> rank_op, weight) with a single-cycle,
//               fully parallel, lowest-index-wins lookup.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_cfg_*             - entry write / clear-all
//               i_lookup_flow_id    - flowID to search for
//               o_hit/o_rank_op/o_weight - combinational lookup result
// Revision    : 1.0 - initial release
// ============================================================================
module rank_flow_table #(
    parameter int FLOW_ID_WIDTH     = 16,
    parameter int FLOW_WEIGHT_WIDTH = 8,
    parameter int MAX_NUM_FLOWS     = 4,
    parameter int RANK_CODE_BITS    = 2,
    parameter int IDX_W             = 2
) (
    input  wire                          clk,
    input  wire                          rst,
    input  wire                          i_cfg_wr_en,
    input  wire  [IDX_W-1:0]             i_cfg_idx,
    input  wire  [FLOW_ID_WIDTH-1:0]     i_cfg_flow_id,
    input  wire  [RANK_CODE_BITS-1:0]    i_cfg_rank_op,
    input  wire  [FLOW_WEIGHT_WIDTH-1:0] i_cfg_weight,
    input  wire                          i_cfg_clr,
    input  wire  [FLOW_ID_WIDTH-1:0]     i_lookup_flow_id,
    output logic                         o_hit,
    output logic [RANK_CODE_BITS-1:0]    o_rank_op,
    output logic [FLOW_WEIGHT_WIDTH-1:0] o_weight
);

    logic [MAX_NUM_FLOWS-1:0]     w_match;
    logic [RANK_CODE_BITS-1:0]    w_entry_op     [MAX_NUM_FLOWS];
    logic [FLOW_WEIGHT_WIDTH-1:0] w_entry_weight [MAX_NUM_FLOWS];

    for (genvar gi = 0; gi < MAX_NUM_FLOWS; gi++) begin : g_entry
        logic                         r_valid;
        logic [FLOW_ID_WIDTH-1:0]     r_flow_id;
        logic [RANK_CODE_BITS-1:0]    r_op;
        logic [FLOW_WEIGHT_WIDTH-1:0] r_weight;

        // Clear-all beats a simultaneous write. Writes land at the clock
        // edge, so a lookup in the same cycle still sees the old entry.
        always_ff @(posedge clk) begin
            if (rst || i_cfg_clr) begin
                r_valid <= 1'b0;
            end else if (i_cfg_wr_en && (i_cfg_idx == IDX_W'(gi))) begin
                r_valid   <= 1'b1;
                r_flow_id <= i_cfg_flow_id;
                r_op      <= i_cfg_rank_op;
                r_weight  <= i_cfg_weight;
            end
        end

        assign w_match[gi]        = r_valid && (r_flow_id == i_lookup_flow_id);
        assign w_entry_op[gi]     = r_op;
        assign w_entry_weight[gi] = r_weight;
    end

    // Scan from the top down so the lowest matching index is assigned last.
    always_comb begin
        o_hit     = 1'b0;
        o_rank_op = '0;
        o_weight  = '0;
        for (int j = MAX_NUM_FLOWS - 1; j >= 0; j--) begin
            if (w_match[j]) begin
                o_hit     = 1'b1;
                o_rank_op = w_entry_op[j];
                o_weight  = w_entry_weight[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rank_insert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rank_insert_ctrl
// Description : Accepts flow descriptors, looks the flowID up in a flow
//               table and issues one insert to the rank pipe per descriptor
//               (IDLE -> LOOKUP -> ISSUE). Misses use rank_op 0 / weight 1
//               and are counted in a saturating miss counter.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               cfg_*        - flow-table write / clear-all
//               ifc (slave)  - descriptor stream, busy, insert + data
//               miss_count   - saturating count of table misses
// Options     : RANK_INSERT_CTRL_MISS_DROP_EN - when defined, missed
//               descriptors are dropped instead of inserted.
// Revision    : 1.0 - initial release
// ============================================================================
module rank_insert_ctrl
    import rank_pkg::*;
#(
    parameter int  FLOW_ID_WIDTH     = 16,
    parameter int  FLOW_WEIGHT_WIDTH = 8,
    parameter int  MAX_NUM_FLOWS     = 4,
    parameter int  RANK_CODE_BITS    = 2,
    parameter int  META_WIDTH        = 16,
    parameter int  NUM_RANK_OPS      = 1,
    localparam int IDX_W = (MAX_NUM_FLOWS > 1) ? $clog2(MAX_NUM_FLOWS) : 1
) (
    input  wire                         clk,
    input  wire                         rst,
    input  wire                         cfg_wr_en,
    input  wire [IDX_W-1:0]             cfg_idx,
    input  wire [FLOW_ID_WIDTH-1:0]     cfg_flowID,
    input  wire [RANK_CODE_BITS-1:0]    cfg_rank_op,
    input  wire [FLOW_WEIGHT_WIDTH-1:0] cfg_weight,
    input  wire                         cfg_clr,
    rank_insert_if.slave                ifc,
    output logic [31:0]                 miss_count
);

    state_t                       r_state;
    logic [FLOW_ID_WIDTH-1:0]     r_cap_flow_id;
    logic [META_WIDTH-1:0]        r_cap_meta;
    logic [META_WIDTH-1:0]        r_ins_meta;
    logic [FLOW_ID_WIDTH-1:0]     r_ins_flow_id;
    logic [RANK_CODE_BITS-1:0]    r_ins_rank_op;
    logic [FLOW_WEIGHT_WIDTH-1:0] r_ins_weight;
    logic [31:0]                  r_miss_count;

    logic                         w_hit;
    logic [RANK_CODE_BITS-1:0]    w_hit_rank_op;
    logic [FLOW_WEIGHT_WIDTH-1:0] w_hit_weight;
    logic [RANK_CODE_BITS-1:0]    w_issue_rank_op;
    logic [FLOW_WEIGHT_WIDTH-1:0] w_issue_weight;
    logic                         w_drop;

    rank_flow_table #(
        .FLOW_ID_WIDTH     (FLOW_ID_WIDTH),
        .FLOW_WEIGHT_WIDTH (FLOW_WEIGHT_WIDTH),
        .MAX_NUM_FLOWS     (MAX_NUM_FLOWS),
        .RANK_CODE_BITS    (RANK_CODE_BITS),
        .IDX_W             (IDX_W)
    ) u_flow_table (
        .clk              (clk),
        .rst              (rst),
        .i_cfg_wr_en      (cfg_wr_en),
        .i_cfg_idx        (cfg_idx),
        .i_cfg_flow_id    (cfg_flowID),
        .i_cfg_rank_op    (cfg_rank_op),
        .i_cfg_weight     (cfg_weight),
        .i_cfg_clr        (cfg_clr),
        .i_lookup_flow_id (r_cap_flow_id),
        .o_hit            (w_hit),
        .o_rank_op        (w_hit_rank_op),
        .o_weight         (w_hit_weight)
    );

    // Table entries may hold op codes the rank pipe does not implement;
    // those fall back to op 0.
    always_comb begin
        w_issue_rank_op = RANK_CODE_BITS'(c_miss_rank_op);
        w_issue_weight  = FLOW_WEIGHT_WIDTH'(c_miss_weight);
        if (w_hit) begin
            w_issue_rank_op = (32'(w_hit_rank_op) >= 32'(NUM_RANK_OPS)) ? '0 : w_hit_rank_op;
            w_issue_weight  = w_hit_weight;
        end
    end

`ifdef RANK_INSERT_CTRL_MISS_DROP_EN
    assign w_drop = !w_hit;
`else
    assign w_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cap_flow_id <= '0;
            r_cap_meta    <= '0;
            r_ins_meta    <= '0;
            r_ins_flow_id <= '0;
            r_ins_rank_op <= '0;
            r_ins_weight  <= '0;
            r_miss_count  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (ifc.desc_valid) begin
                        r_cap_flow_id <= ifc.desc_flowID;
                        r_cap_meta    <= ifc.desc_meta;
                        r_state       <= c_st_lookup;
                    end
                end
                c_st_lookup: begin
                    if (!w_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
                        r_miss_count <= r_miss_count + 32'd1;
                    end
                    if (w_drop) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_ins_meta    <= r_cap_meta;
                        r_ins_flow_id <= r_cap_flow_id;
                        r_ins_rank_op <= w_issue_rank_op;
                        r_ins_weight  <= w_issue_weight;
                        r_state       <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    // Insert data is held for the whole ISSUE stay and is
                    // zeroed once the insert has been taken.
                    if (!ifc.busy) begin
                        r_ins_meta    <= '0;
                        r_ins_flow_id <= '0;
                        r_ins_rank_op <= '0;
                        r_ins_weight  <= '0;
                        r_state       <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Gated by rst so neither handshake fires during a reset cycle;
    // insert follows busy combinationally to hit the first idle cycle.
    assign ifc.desc_ready     = (r_state == c_st_idle) && !rst;
    assign ifc.insert         = (r_state == c_st_issue) && !ifc.busy && !rst;
    assign ifc.meta_in        = r_ins_meta;
    assign ifc.rank_op_in     = r_ins_rank_op;
    assign ifc.flowID_in      = r_ins_flow_id;
    assign ifc.flow_weight_in = r_ins_weight;
    assign miss_count         = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_rank_insert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rank_insert_ctrl
// Description : Self-checking bench for rank_insert_ctrl. Directed cases for
//               hit/miss/backpressure/priority/op-clamp/reset, then random
//               descriptors against a table-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rank_insert_ctrl;

    localparam int FLOW_ID_WIDTH     = 16;
    localparam int FLOW_WEIGHT_WIDTH = 8;
    localparam int MAX_NUM_FLOWS     = 4;
    localparam int RANK_CODE_BITS    = 2;
    localparam int META_WIDTH        = 16;
    localparam int NUM_RANK_OPS      = 1;
    localparam int IDX_W             = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         cfg_wr_en;
    logic [IDX_W-1:0]             cfg_idx;
    logic [FLOW_ID_WIDTH-1:0]     cfg_flowID;
    logic [RANK_CODE_BITS-1:0]    cfg_rank_op;
    logic [FLOW_WEIGHT_WIDTH-1:0] cfg_weight;
    logic                         cfg_clr;
    logic [31:0]                  miss_count;

    rank_insert_if #(
        .FLOW_ID_WIDTH(FLOW_ID_WIDTH), .FLOW_WEIGHT_WIDTH(FLOW_WEIGHT_WIDTH),
        .RANK_CODE_BITS(RANK_CODE_BITS), .META_WIDTH(META_WIDTH)
    ) bus ();

    rank_insert_ctrl #(
        .FLOW_ID_WIDTH(FLOW_ID_WIDTH), .FLOW_WEIGHT_WIDTH(FLOW_WEIGHT_WIDTH),
        .MAX_NUM_FLOWS(MAX_NUM_FLOWS), .RANK_CODE_BITS(RANK_CODE_BITS),
        .META_WIDTH(META_WIDTH), .NUM_RANK_OPS(NUM_RANK_OPS)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx),
        .cfg_flowID(cfg_flowID), .cfg_rank_op(cfg_rank_op), .cfg_weight(cfg_weight),
        .cfg_clr(cfg_clr), .ifc(bus), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: the flow table as plain arrays plus a miss tally.
    bit          m_valid [MAX_NUM_FLOWS];
    logic [15:0] m_fid   [MAX_NUM_FLOWS];
    int          m_op    [MAX_NUM_FLOWS];
    int          m_wt    [MAX_NUM_FLOWS];
    int unsigned m_miss;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ins_data();
        return 64'({bus.meta_in, bus.rank_op_in, bus.flowID_in, bus.flow_weight_in});
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < MAX_NUM_FLOWS; i++) m_valid[i] = 1'b0;
    endfunction

    // First valid matching entry in ascending order; unimplemented ops -> 0.
    function automatic void model_lookup(input logic [15:0] fid, output bit hit,
                                         output int op, output int wt);
        hit = 1'b0; op = 0; wt = 1;
        for (int i = 0; i < MAX_NUM_FLOWS; i++) begin
            if (m_valid[i] && m_fid[i] == fid) begin
                hit = 1'b1;
                op  = (m_op[i] >= NUM_RANK_OPS) ? 0 : m_op[i];
                wt  = m_wt[i];
                break;
            end
        end
    endfunction

    task automatic cfg_write(input int idx, input logic [15:0] fid, input int op, input int wt);
        cfg_wr_en = 1'b1; cfg_idx = IDX_W'(idx); cfg_flowID = fid;
        cfg_rank_op = RANK_CODE_BITS'(op); cfg_weight = FLOW_WEIGHT_WIDTH'(wt);
        tick();
        cfg_wr_en = 1'b0;
        m_valid[idx] = 1'b1; m_fid[idx] = fid; m_op[idx] = op; m_wt[idx] = wt;
    endtask

    task automatic cfg_clear();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        model_clear();
    endtask

    // lk_mode: 0 none, 1 write during lookup, 2 clear during lookup, 3 both.
    task automatic run_txn(input logic [15:0] fid, input logic [15:0] meta,
                           input int busy_cycles, input int lk_mode);
        bit          hit;
        int          eop, ewt, wr_idx, wr_op, wr_wt;
        // accept cycle
        bus.desc_valid = 1'b1; bus.desc_flowID = fid; bus.desc_meta = meta;
        bus.busy = 1'($urandom_range(0, 1));
        #2;
        check_val("accept_ready", 64'(bus.desc_ready), 1);
        check_val("idle_insert", 64'(bus.insert), 0);
        check_val("idle_data", ins_data(), 0);
        tick();
        // lookup cycle: result is fixed by the table as it stands now
        model_lookup(fid, hit, eop, ewt);
        bus.desc_valid = 1'($urandom_range(0, 1));
        bus.desc_flowID = 16'($urandom); bus.desc_meta = 16'($urandom);
        bus.busy = 1'($urandom_range(0, 1));
        wr_idx = $urandom_range(0, MAX_NUM_FLOWS - 1);
        wr_op = $urandom_range(0, 3); wr_wt = $urandom_range(0, 255);
        cfg_wr_en = (lk_mode == 1 || lk_mode == 3); cfg_clr = (lk_mode >= 2);
        cfg_idx = IDX_W'(wr_idx); cfg_flowID = fid;
        cfg_rank_op = RANK_CODE_BITS'(wr_op); cfg_weight = FLOW_WEIGHT_WIDTH'(wr_wt);
        #2;
        check_val("lookup_ready", 64'(bus.desc_ready), 0);
        check_val("lookup_insert", 64'(bus.insert), 0);
        check_val("lookup_data", ins_data(), 0);
        tick();
        cfg_wr_en = 1'b0; cfg_clr = 1'b0;
        if (lk_mode >= 2) model_clear();
        else if (lk_mode == 1) begin
            m_valid[wr_idx] = 1'b1; m_fid[wr_idx] = fid; m_op[wr_idx] = wr_op; m_wt[wr_idx] = wr_wt;
        end
        if (!hit) m_miss++;
        check_val("miss_count", 64'(miss_count), 64'(m_miss));
`ifdef RANK_INSERT_CTRL_MISS_DROP_EN
        if (!hit) begin
            bus.desc_valid = 1'b0; bus.busy = 1'b0;
            #2;
            check_val("drop_ready", 64'(bus.desc_ready), 1);
            check_val("drop_insert", 64'(bus.insert), 0);
            tick();
            return;
        end
`endif
        for (int k = 0; k < busy_cycles; k++) begin
            bus.busy = 1'b1; bus.desc_valid = 1'($urandom_range(0, 1));
            #2;
            check_val("busy_insert", 64'(bus.insert), 0);
            check_val("busy_ready", 64'(bus.desc_ready), 0);
            check_val("busy_meta", 64'(bus.meta_in), 64'(meta));
            check_val("busy_weight", 64'(bus.flow_weight_in), 64'(ewt));
            tick();
        end
        bus.busy = 1'b0; bus.desc_valid = 1'b0;
        #2;
        check_val("issue_insert", 64'(bus.insert), 1);
        check_val("issue_ready", 64'(bus.desc_ready), 0);
        check_val("issue_meta", 64'(bus.meta_in), 64'(meta));
        check_val("issue_flow", 64'(bus.flowID_in), 64'(fid));
        check_val("issue_op", 64'(bus.rank_op_in), 64'(eop));
        check_val("issue_weight", 64'(bus.flow_weight_in), 64'(ewt));
        tick();
    endtask

    int ncfg, bcyc, lk;

    initial begin
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_clr = 1'b0; cfg_idx = '0;
        cfg_flowID = '0; cfg_rank_op = '0; cfg_weight = '0;
        bus.desc_valid = 1'b0; bus.desc_flowID = '0; bus.desc_meta = '0; bus.busy = 1'b0;
        model_clear(); m_miss = 0;
        tick();
        #2;
        check_val("rst_ready", 64'(bus.desc_ready), 0);
        check_val("rst_insert", 64'(bus.insert), 0);
        tick();
        rst = 1'b0;
        #2;
        check_val("post_rst_miss", 64'(miss_count), 0);
        check_val("post_rst_ready", 64'(bus.desc_ready), 1);
        tick();

        // basic hit, miss, long backpressure
        cfg_write(0, 16'h0005, 0, 3);
        run_txn(16'h0005, 16'hABCD, 0, 0);
        run_txn(16'h0009, 16'h1234, 0, 0);
        run_txn(16'h0005, 16'h5555, 10, 0);
        // lowest index wins; unimplemented op clamps to 0
        cfg_write(3, 16'h0007, 0, 8);
        cfg_write(1, 16'h0007, 0, 4);
        run_txn(16'h0007, 16'h0777, 1, 0);
        cfg_write(2, 16'h0020, 3, 9);
        run_txn(16'h0020, 16'h2020, 0, 0);
        // cfg during lookup is seen only by later lookups
        run_txn(16'h0005, 16'h0101, 0, 2);
        run_txn(16'h0005, 16'h0202, 0, 0);
        run_txn(16'h0030, 16'h0303, 0, 1);
        run_txn(16'h0030, 16'h0404, 2, 0);

        // reset while waiting in ISSUE
        cfg_write(0, 16'h0011, 1, 5);
        bus.desc_valid = 1'b1; bus.desc_flowID = 16'h0011; bus.desc_meta = 16'h0BAD;
        tick();
        bus.desc_valid = 1'b0; bus.busy = 1'b1;
        tick();
        tick();
        rst = 1'b1; bus.busy = 1'b0;
        #2;
        check_val("midrst_insert", 64'(bus.insert), 0);
        check_val("midrst_ready", 64'(bus.desc_ready), 0);
        tick();
        rst = 1'b0;
        model_clear(); m_miss = 0;
        #2;
        check_val("midrst_miss", 64'(miss_count), 0);
        check_val("midrst_idle", 64'(bus.desc_ready), 1);
        check_val("midrst_data", ins_data(), 0);
        tick();
        run_txn(16'h0011, 16'h0C0C, 0, 0);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            ncfg = $urandom_range(0, 2);
            for (int c = 0; c < ncfg; c++)
                cfg_write($urandom_range(0, MAX_NUM_FLOWS - 1), 16'($urandom_range(1, 6)),
                          $urandom_range(0, 3), $urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) cfg_clear();
            bcyc = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 3);
            lk   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            run_txn(16'($urandom_range(1, 7)), 16'($urandom), bcyc, lk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
